pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the multi-cycle CPU.

---
 rtl/pc_fetch_unit_pkg.sv | 16 +
 rtl/pc_fetch_unit.sv | 111 +++++++++++
 tb/tb_pc_fetch_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU package for the fetch path.
// Provides the default reset PC, the 32-bit word type and the fetch
// sequencer state encoding used by pc_fetch_unit.
package pc_fetch_unit_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_3000;

    // IDLE: no fetch outstanding; WAIT: request held until memory acks.
    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds pc, issues a single outstanding fetch to instruction memory, latches
// the returned word into ir, and exposes pc+4, instr_index and the
// sign-extended offset for the next-PC selector. Accepts the selected next
// pc back on pc_we.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   fetch_start   start a fetch (ignored while a fetch is in flight)
//   pc_we, npc    commit npc into pc (word-aligned only, IDLE only)
//   imem_req/addr request to instruction memory, addr = pc
//   imem_ack/rdata memory response, sampled only while waiting
//   pc, npc_t     current pc and pc+4 of the instruction in ir
//   ir, ir_valid  instruction register and its unconsumed flag
//   instr_index   ir[25:0]
//   offset        sign-extended ir[15:0]
//   busy          fetch in flight
//   addr_err      sticky: misaligned npc was rejected
//   seq_err       sticky: pc_we arrived while a fetch was in flight
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_we,
    input  logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] npc_t,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [25:0] instr_index,
    output logic [31:0] offset,
    output logic        busy,
    output logic        addr_err,
    output logic        seq_err
);

    fetch_state_e state_q;
    word_t        pc_q;
    word_t        npc_t_q;
    word_t        ir_q;
    logic         ir_valid_q;
    logic         addr_err_q;
    logic         seq_err_q;
    word_t        pc_plus4_d;

    assign pc_plus4_d = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            npc_t_q    <= RESET_PC + 32'd4;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    // pc update and fetch launch share the edge, so the
                    // fetch in WAIT addresses the freshly committed pc.
                    if (pc_we) begin
                        if (npc[1:0] == 2'b00) begin
                            pc_q       <= npc;
                            ir_valid_q <= 1'b0;
                        end else begin
                            addr_err_q <= 1'b1;
                        end
                    end
                    if (fetch_start) begin
                        state_q    <= FETCH_WAIT;
                        ir_valid_q <= 1'b0;
                    end
                end
                FETCH_WAIT: begin
                    if (pc_we) begin
                        seq_err_q <= 1'b1;
                    end
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        npc_t_q    <= pc_plus4_d;
                        ir_valid_q <= 1'b1;
                        state_q    <= FETCH_IDLE;
                    end
                end
                default: state_q <= FETCH_IDLE;
            endcase
        end
    end

    assign imem_req    = (state_q == FETCH_WAIT);
    assign busy        = (state_q == FETCH_WAIT);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign npc_t       = npc_t_q;
    assign ir          = ir_q;
    assign ir_valid    = ir_valid_q;
    assign instr_index = ir_q[25:0];
    assign offset      = {{16{ir_q[15]}}, ir_q[15:0]};
    assign addr_err    = addr_err_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic, all tracked by a transaction-level
// model and compared on every falling edge.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_start;
    logic        pc_we;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] npc_t;
    logic [31:0] ir;
    logic        ir_valid;
    logic [25:0] instr_index;
    logic [31:0] offset;
    logic        busy;
    logic        addr_err;
    logic        seq_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          cmp_en   = 1'b0;

    // Model state: what the unit must hold, in transaction terms.
    logic [31:0] m_pc;
    logic [31:0] m_npc_t;
    logic [31:0] m_ir;
    bit          m_ir_valid;
    bit          m_in_flight;
    bit          m_addr_err;
    bit          m_seq_err;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_we(pc_we),
        .npc(npc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
        .npc_t(npc_t), .ir(ir), .ir_valid(ir_valid),
        .instr_index(instr_index), .offset(offset), .busy(busy),
        .addr_err(addr_err), .seq_err(seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext16(input logic [15:0] h);
        int signed v;
        v = $signed(h);
        return 32'(v);
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_step();
        if (rst) begin
            m_pc = 32'h3000; m_npc_t = 32'h3004; m_ir = '0;
            m_ir_valid = 0; m_in_flight = 0; m_addr_err = 0; m_seq_err = 0;
        end else if (m_in_flight) begin
            if (pc_we) m_seq_err = 1;
            if (imem_ack) begin
                m_ir = imem_rdata;
                m_npc_t = m_pc + 32'd4;
                m_ir_valid = 1;
                m_in_flight = 0;
            end
        end else begin
            if (pc_we) begin
                if (npc % 4 == 0) begin
                    m_pc = npc;
                    m_ir_valid = 0;
                end else begin
                    m_addr_err = 1;
                end
            end
            if (fetch_start) begin
                m_in_flight = 1;
                m_ir_valid = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pc", pc, m_pc);
            chk("m_npc_t", npc_t, m_npc_t);
            chk("m_ir", ir, m_ir);
            chk("m_ir_valid", 32'(ir_valid), 32'(m_ir_valid));
            chk("m_busy", 32'(busy), 32'(m_in_flight));
            chk("m_imem_req", 32'(imem_req), 32'(m_in_flight));
            if (m_in_flight) chk("m_imem_addr", imem_addr, m_pc);
            chk("m_instr_index", 32'(instr_index), m_ir & 32'h03FF_FFFF);
            chk("m_offset", offset, sext16(m_ir[15:0]));
            chk("m_addr_err", 32'(addr_err), 32'(m_addr_err));
            chk("m_seq_err", 32'(seq_err), 32'(m_seq_err));
        end
    end

    initial begin
        rst = 1'b1; fetch_start = 0; pc_we = 0; npc = '0;
        imem_ack = 0; imem_rdata = '0;

        // 1: reset
        tick(); tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_npc_t", npc_t, 32'h3004);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_flags", {30'd0, addr_err, seq_err}, 32'd0);

        // 2: fetch with ack three cycles after req
        fetch_start = 1; tick(); fetch_start = 0;
        for (int i = 0; i < 3; i++) begin
            chk("f2_req", 32'(imem_req), 32'd1);
            chk("f2_addr", imem_addr, 32'h3000);
            tick();
        end
        chk("f2_addr_at_ack", imem_addr, 32'h3000);
        imem_ack = 1; imem_rdata = 32'h0800_0C04; tick(); imem_ack = 0;
        chk("f2_ir", ir, 32'h0800_0C04);
        chk("f2_index", 32'(instr_index), 32'h0000_0C04);
        chk("f2_ir_valid", 32'(ir_valid), 32'd1);
        chk("f2_npc_t", npc_t, 32'h3004);
        chk("f2_busy", 32'(busy), 32'd0);

        // 3: negative offset, aligned pc_we
        fetch_start = 1; tick(); fetch_start = 0;
        imem_ack = 1; imem_rdata = 32'h1000_FFFE; tick(); imem_ack = 0;
        chk("f3_offset", offset, 32'hFFFF_FFFE);
        pc_we = 1; npc = 32'h2FFC; tick(); pc_we = 0;
        chk("f3_pc", pc, 32'h2FFC);
        chk("f3_ir_valid", 32'(ir_valid), 32'd0);

        // 4: misaligned pc_we, sticky addr_err
        pc_we = 1; npc = 32'h3002; tick(); pc_we = 0;
        chk("f4_pc", pc, 32'h2FFC);
        chk("f4_addr_err", 32'(addr_err), 32'd1);
        tick(); tick();
        chk("f4_addr_err_sticky", 32'(addr_err), 32'd1);

        // 5: pc_we during WAIT
        fetch_start = 1; tick(); fetch_start = 0;
        pc_we = 1; npc = 32'h4000; tick(); pc_we = 0;
        chk("f5_pc", pc, 32'h2FFC);
        chk("f5_seq_err", 32'(seq_err), 32'd1);
        chk("f5_busy", 32'(busy), 32'd1);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_ack = 0;
        chk("f5_ir", ir, 32'hDEAD_BEEF);
        chk("f5_ir_valid", 32'(ir_valid), 32'd1);
        chk("f5_npc_t", npc_t, 32'h3000);

        // 6: pc_we + fetch_start together, wraparound, reset mid-WAIT
        pc_we = 1; npc = 32'hFFFF_FFFC; fetch_start = 1; tick();
        pc_we = 0; fetch_start = 0;
        chk("f6_addr", imem_addr, 32'hFFFF_FFFC);
        chk("f6_req", 32'(imem_req), 32'd1);
        imem_ack = 1; imem_rdata = 32'h0000_1234; tick(); imem_ack = 0;
        chk("f6_npc_t_wrap", npc_t, 32'h0000_0000);
        fetch_start = 1; tick(); fetch_start = 0;
        chk("f6_busy_pre_rst", 32'(busy), 32'd1);
        rst = 1; tick(); rst = 0;
        chk("f6_req_after_rst", 32'(imem_req), 32'd0);
        chk("f6_pc_after_rst", pc, 32'h3000);
        chk("f6_flags_after_rst", {30'd0, addr_err, seq_err}, 32'd0);

        // Misaligned npc with fetch_start: fetch uses old pc
        pc_we = 1; npc = 32'h0000_5001; fetch_start = 1; tick();
        pc_we = 0; fetch_start = 0;
        chk("f7_addr_old_pc", imem_addr, 32'h3000);
        chk("f7_addr_err", 32'(addr_err), 32'd1);
        imem_ack = 1; imem_rdata = 32'h0000_8000; tick(); imem_ack = 0;
        chk("f7_offset", offset, 32'hFFFF_8000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            fetch_start = ($urandom_range(0, 2) == 0);
            pc_we       = ($urandom_range(0, 5) == 0);
            npc         = $urandom;
            if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) npc = 32'hFFFF_FFFC;
            imem_ack    = ($urandom_range(0, 2) == 0);
            imem_rdata  = $urandom;
            tick();
        end
        rst = 0; fetch_start = 0; pc_we = 0; imem_ack = 0;
        tick();
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
